regs_param: RTL and testbench

- Parametrised successor to the fixed 32x32 two-read/one-write register file.
- Width, depth and address size are generics.
- Reads are registered, with a valid flag.
- Optional hard-wired zero register and optional write-to-read bypass.
- `clear` is a multi-cycle sweep sequencer with a busy flag, so the array can map to RAM instead of flops.
- Sits in the datapath as the CPU general-register file and is reused for scratch register banks.

---
 rtl/regs_param.sv | 158 +++++++++++++++
 tb/tb_regs_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regs_param.sv
// Parametrised two-read/one-write register file with registered reads, optional zero
// register and write bypass, and a one-entry-per-cycle clear sweep so the array can map to RAM.
module regs_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             read_a,
    input  logic [AW-1:0]    a_addr,
    output logic [WIDTH-1:0] a,
    output logic             a_valid,
    input  logic             read_b,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    input  logic             write,
    input  logic [AW-1:0]    in_addr,
    input  logic [WIDTH-1:0] in,
    input  logic             clear,
    output logic             busy,
    output logic             wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One extra pointer bit so DEPTH == 2**AW reaches its last entry without wrapping.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW:0]      ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic             wr_drop_q, wr_drop_d;

    logic             busy_w;
    logic             wr_in_range, wr_zero, wr_ok;
    logic [WIDTH-1:0] a_raw, b_raw;

    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_W) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    // Final read value: blanked while sweeping, forwarded or stored otherwise.
    function automatic logic [WIDTH-1:0] sel_read(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             blank,
        input logic             fwd,
        input logic [WIDTH-1:0] wdata
    );
        if (blank || !addr_ok(addr)) return '0;
        if (fwd && (BYPASS != 0))    return wdata;
        return stored;
    endfunction

    assign busy_w      = (state_q == CLEAR);
    assign wr_in_range = ({1'b0, in_addr} < DEPTH_W);
    assign wr_zero     = (ZERO_REG != 0) && (in_addr == '0);
    assign wr_ok       = write && wr_in_range && !wr_zero && !busy_w && !clear;

    always_comb begin
        a_raw = '0;
        b_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_addr == AW'(i)) a_raw = mem_q[i];
            if (b_addr == AW'(i)) b_raw = mem_q[i];
        end
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        a_valid_d = read_a;
        b_valid_d = read_b;
        wr_drop_d = write && !wr_zero && (!wr_in_range || busy_w || clear);
        if (read_a)
            a_d = sel_read(a_addr, a_raw, busy_w || clear, wr_ok && (a_addr == in_addr), in);
        if (read_b)
            b_d = sel_read(b_addr, b_raw, busy_w || clear, wr_ok && (b_addr == in_addr), in);
    end

    // Sweep writes and normal writes never coincide: writes are refused while busy.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_w && (ptr_q == (AW+1)'(i)))
                mem_d[i] = '0;
            else if (wr_ok && (in_addr == AW'(i)))
                mem_d[i] = in;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == LAST_W) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + (AW+1)'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            wr_drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            wr_drop_q <= wr_drop_d;
            mem_q     <= mem_d;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign a_valid = a_valid_q;
    assign b_valid = b_valid_q;
    assign busy    = busy_w;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regs_param.sv
// Directed bench for regs_param: a 32-deep bypassing instance and a 20-deep
// non-bypassing instance share one stimulus stream, each with its own expected values.
module tb_regs_param;

    logic        m_clock;
    logic        p_reset;
    logic        read_a, read_b, write, clear;
    logic [4:0]  a_addr, b_addr, in_addr;
    logic [31:0] in;

    logic [31:0] a1, b1, a2, b2;
    logic        a_valid1, b_valid1, busy1, wr_drop1;
    logic        a_valid2, b_valid2, busy2, wr_drop2;

    int total = 0;
    int bad   = 0;

    regs_param #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut1 (
        .m_clock(m_clock), .p_reset(p_reset),
        .read_a(read_a), .a_addr(a_addr), .a(a1), .a_valid(a_valid1),
        .read_b(read_b), .b_addr(b_addr), .b(b1), .b_valid(b_valid1),
        .write(write), .in_addr(in_addr), .in(in),
        .clear(clear), .busy(busy1), .wr_drop(wr_drop1)
    );

    regs_param #(.WIDTH(32), .DEPTH(20), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut2 (
        .m_clock(m_clock), .p_reset(p_reset),
        .read_a(read_a), .a_addr(a_addr), .a(a2), .a_valid(a_valid2),
        .read_b(read_b), .b_addr(b_addr), .b(b2), .b_valid(b_valid2),
        .write(write), .in_addr(in_addr), .in(in),
        .clear(clear), .busy(busy2), .wr_drop(wr_drop2)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    typedef struct {
        logic        ra;
        logic [4:0]  aa;
        logic        rb;
        logic [4:0]  ba;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        clr;
        logic        av;
        logic [31:0] ea;
        logic        bv;
        logic [31:0] eb;
        logic        d1;
        logic [31:0] ea2;
        logic        d2;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        read_a = 1'b0; a_addr = '0;
        read_b = 1'b0; b_addr = '0;
        write  = 1'b0; in_addr = '0; in = '0;
        clear  = 1'b0;
    endtask

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        string s;
        read_a = v.ra; a_addr = v.aa;
        read_b = v.rb; b_addr = v.ba;
        write  = v.wr; in_addr = v.wa; in = v.wd;
        clear  = v.clr;
        tick();
        s = $sformatf("vec%0d", idx);
        chk({s, " a_valid"}, 32'(a_valid1), 32'(v.av));
        chk({s, " b_valid"}, 32'(b_valid1), 32'(v.bv));
        chk({s, " wr_drop"}, 32'(wr_drop1), 32'(v.d1));
        chk({s, " wr_drop2"}, 32'(wr_drop2), 32'(v.d2));
        chk({s, " busy"}, 32'(busy1), 32'(0));
        if (v.av) begin
            chk({s, " a"}, a1, v.ea);
            chk({s, " a2"}, a2, v.ea2);
        end
        if (v.bv) chk({s, " b"}, b1, v.eb);
        idle_in();
    endtask

    initial begin
        int n1, n2;

        // ra aa rb ba | wr wa wd clr | av ea bv eb d1 | ea2 d2
        vecs[0]  = '{1'b1, 5'd5,  1'b1, 5'd31, 1'b0, 5'd0,  32'h0,        1'b0,
                     1'b1, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd7,  32'hDEADBEEF, 1'b0,
                     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 5'd7,  1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        1'b0,
                     1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 5'd3,  32'h12345678, 1'b0,
                     1'b1, 32'h12345678, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 5'd3,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0,
                     1'b1, 32'h12345678, 1'b0, 32'h0,        1'b0, 32'h12345678, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 1'b0,
                     1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0,
                     1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd25, 32'hA5A5A5A5, 1'b0,
                     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 5'd25, 1'b1, 5'd25, 1'b0, 5'd0,  32'h0,        1'b0,
                     1'b1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 5'd7,  1'b1, 5'd31, 1'b1, 5'd31, 32'h00000055, 1'b0,
                     1'b1, 32'hDEADBEEF, 1'b1, 32'h00000055, 1'b0, 32'hDEADBEEF, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  1'b1, 5'd31, 1'b0, 5'd0,  32'h0,        1'b0,
                     1'b0, 32'h0,        1'b1, 32'h00000055, 1'b0, 32'h0,        1'b0};

        idle_in();
        p_reset = 1'b1;
        #2 p_reset = 1'b0;
        #1;
        chk("rst a",       a1,               32'h0);
        chk("rst b",       b1,               32'h0);
        chk("rst a_valid", 32'(a_valid1),    32'(0));
        chk("rst b_valid", 32'(b_valid1),    32'(0));
        chk("rst busy",    32'(busy1),       32'(0));
        chk("rst wr_drop", 32'(wr_drop1),    32'(0));
        chk("rst busy2",   32'(busy2),       32'(0));
        @(posedge m_clock);
        @(posedge m_clock);
        @(negedge m_clock);
        p_reset = 1'b1;

        for (int i = 0; i < 11; i++) apply(vecs[i], i);

        // Load entries 1..31 with i*0x11; the 20-deep instance drops 20 and above.
        for (int i = 1; i < 32; i++) begin
            write = 1'b1; in_addr = 5'(i); in = 32'(i * 32'h11);
            tick();
            chk($sformatf("load%0d wr_drop", i), 32'(wr_drop1), 32'(0));
            chk($sformatf("load%0d wr_drop2", i), 32'(wr_drop2), 32'(i >= 20));
            idle_in();
        end
        read_a = 1'b1; a_addr = 5'd4; read_b = 1'b1; b_addr = 5'd31;
        tick();
        chk("load rd a4",  a1, 32'h44);
        chk("load rd b31", b1, 32'h20F);
        chk("load rd a2",  a2, 32'h44);
        idle_in();

        // Clear pulse with a colliding write and read: write dropped, read blanked.
        clear = 1'b1; write = 1'b1; in_addr = 5'd4; in = 32'h99;
        read_a = 1'b1; a_addr = 5'd4;
        tick();
        chk("clr wr_drop",  32'(wr_drop1), 32'(1));
        chk("clr wr_drop2", 32'(wr_drop2), 32'(1));
        chk("clr busy",     32'(busy1),    32'(1));
        chk("clr rd a",     a1,            32'h0);
        chk("clr a_valid",  32'(a_valid1), 32'(1));
        n1 = busy1 ? 1 : 0;
        n2 = busy2 ? 1 : 0;
        idle_in();

        write = 1'b1; in_addr = 5'd9; in = 32'h1; read_a = 1'b1; a_addr = 5'd4;
        tick();
        chk("busy wr_drop", 32'(wr_drop1), 32'(1));
        chk("busy rd a",    a1,            32'h0);
        if (busy1) n1++;
        if (busy2) n2++;
        idle_in();

        for (int k = 0; k < 100; k++) begin
            if (!busy1 && !busy2) break;
            tick();
            if (busy1) n1++;
            if (busy2) n2++;
        end
        chk("sweep ended",  32'(busy1), 32'(0));
        chk("busy cycles",  32'(n1),    32'd32);
        chk("busy2 cycles", 32'(n2),    32'd20);
        chk("post wr_drop", 32'(wr_drop1), 32'(0));

        write = 1'b1; in_addr = 5'd4; in = 32'h4242; read_b = 1'b1; b_addr = 5'd17;
        tick();
        chk("idle wr_drop",  32'(wr_drop1), 32'(0));
        chk("idle wr_drop2", 32'(wr_drop2), 32'(0));
        chk("idle rd b17",   b1,            32'h0);
        idle_in();

        for (int i = 1; i < 32; i++) begin
            read_a = 1'b1; a_addr = 5'(i);
            tick();
            chk($sformatf("swept a%0d", i),  a1, (i == 4) ? 32'h4242 : 32'h0);
            chk($sformatf("swept a2_%0d", i), a2, (i == 4) ? 32'h4242 : 32'h0);
            idle_in();
        end

        // Asynchronous reset in the middle of a sweep aborts it at once.
        clear = 1'b1;
        tick();
        idle_in();
        tick();
        tick();
        chk("mid busy", 32'(busy1), 32'(1));
        #2 p_reset = 1'b0;
        #1;
        chk("mid rst busy",  32'(busy1), 32'(0));
        chk("mid rst busy2", 32'(busy2), 32'(0));
        @(negedge m_clock);
        p_reset = 1'b1;
        write = 1'b1; in_addr = 5'd6; in = 32'h66;
        tick();
        chk("after rst wr_drop", 32'(wr_drop1), 32'(0));
        chk("after rst busy",    32'(busy1),    32'(0));
        idle_in();
        read_a = 1'b1; a_addr = 5'd6; read_b = 1'b1; b_addr = 5'd4;
        tick();
        chk("after rst a6", a1, 32'h66);
        chk("after rst b4", b1, 32'h0);
        idle_in();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
